// File: rtl/pattern_tx_pkg.sv
// Shared types and constants for the pattern transmitter.
// The GAP state exists only when SEQ_TX_GAP_EN is defined.
package pattern_tx_pkg;

    localparam int         DEFAULT_PAT_W   = 6;
    localparam logic [5:0] DEFAULT_PATTERN = 6'b100110;

`ifdef SEQ_TX_GAP_EN
    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_t;
`else
    typedef enum logic [0:0] {
        IDLE,
        SEND
    } state_t;
`endif

endpackage

// File: rtl/pattern_tx_if.sv
// Control and serial-output bundle of the pattern transmitter.
// The master drives start/rep/abort; the slave (pattern_tx) drives the serial outputs.
interface pattern_tx_if #(
    parameter int REP_W = 4
) ();

    logic             start;
    logic [REP_W-1:0] rep;
    logic             abort;
    logic             dout;
    logic             dvalid;
    logic             busy;
    logic             done;

    modport master (
        output start, rep, abort,
        input  dout, dvalid, busy, done
    );

    modport slave (
        input  start, rep, abort,
        output dout, dvalid, busy, done
    );

endinterface

// File: rtl/pattern_tx_shreg.sv
// Pattern load/shift register with its bit index. Whenever load is low the
// register shifts one bit towards the MSB; next_bit is the bit that becomes current.
module pattern_tx_shreg #(
    parameter int               PAT_W   = 6,
    parameter logic [PAT_W-1:0] PATTERN = 6'b100110
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic next_bit,
    output logic last
);

    localparam int IDX_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;

    logic [PAT_W-1:0] sr;
    logic [IDX_W-1:0] idx;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr  <= PATTERN;
            idx <= IDX_W'(PAT_W - 1);
        end else if (load) begin
            sr  <= PATTERN;
            idx <= IDX_W'(PAT_W - 1);
        end else begin
            sr  <= {sr[PAT_W-2:0], 1'b0};
            idx <= idx - 1'b1;
        end
    end

    assign next_bit = sr[PAT_W-2];
    assign last     = (idx == '0);

endmodule

// File: rtl/pattern_tx.sv
// Serial pattern burst transmitter: sends PATTERN MSB first, rep times per start.
// Define SEQ_TX_GAP_EN to insert GAP_LEN idle cycles between repetitions.
module pattern_tx
    import pattern_tx_pkg::*;
#(
    parameter int               PAT_W   = DEFAULT_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = DEFAULT_PATTERN,
    parameter int               REP_W   = 4,
    parameter int               GAP_LEN = 2
) (
    input  logic         clk,
    input  logic         rst,
    pattern_tx_if.slave  bus
);

    state_t           state;
    logic [REP_W-1:0] remaining;
    logic             dout_q, dvalid_q, busy_q, done_q;
    logic             next_bit, last, load;

`ifdef SEQ_TX_GAP_EN
    localparam int GAP_W = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
    logic [GAP_W-1:0] gap_cnt;
`endif

    // The shift register sits at the first pattern bit whenever it is not mid-pattern.
    assign load = (state != SEND) || last || bus.abort;

    pattern_tx_shreg #(
        .PAT_W   (PAT_W),
        .PATTERN (PATTERN)
    ) u_shreg (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .next_bit (next_bit),
        .last     (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            dout_q    <= 1'b0;
            dvalid_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef SEQ_TX_GAP_EN
            gap_cnt   <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && !bus.abort && (bus.rep != '0)) begin
                        state     <= SEND;
                        remaining <= bus.rep;
                        dout_q    <= PATTERN[PAT_W-1];
                        dvalid_q  <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                SEND: begin
                    if (bus.abort) begin
                        state     <= IDLE;
                        remaining <= '0;
                        dout_q    <= 1'b0;
                        dvalid_q  <= 1'b0;
                        busy_q    <= 1'b0;
                    end else if (!last) begin
                        dout_q <= next_bit;
                    end else if (remaining == REP_W'(1)) begin
                        state     <= IDLE;
                        remaining <= '0;
                        dout_q    <= 1'b0;
                        dvalid_q  <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                    end else begin
                        remaining <= remaining - 1'b1;
`ifdef SEQ_TX_GAP_EN
                        if (GAP_LEN > 0) begin
                            state    <= GAP;
                            gap_cnt  <= GAP_W'(GAP_LEN - 1);
                            dout_q   <= 1'b0;
                            dvalid_q <= 1'b0;
                        end else begin
                            dout_q <= PATTERN[PAT_W-1];
                        end
`else
                        dout_q <= PATTERN[PAT_W-1];
`endif
                    end
                end
`ifdef SEQ_TX_GAP_EN
                GAP: begin
                    if (bus.abort) begin
                        state     <= IDLE;
                        remaining <= '0;
                        busy_q    <= 1'b0;
                    end else if (gap_cnt == '0) begin
                        state    <= SEND;
                        dout_q   <= PATTERN[PAT_W-1];
                        dvalid_q <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    remaining <= '0;
                    dout_q    <= 1'b0;
                    dvalid_q  <= 1'b0;
                    busy_q    <= 1'b0;
                end
`endif
            endcase
        end
    end

    assign bus.dout   = dout_q;
    assign bus.dvalid = dvalid_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

endmodule

// File: tb/tb_pattern_tx.sv
// Self-checking bench for pattern_tx; the expected per-cycle output stream of a
// burst is built from the pattern, repetition count and optional gap length.
module tb_pattern_tx;

    localparam int         PAT_W   = 6;
    localparam logic [5:0] PAT     = 6'b100110;
    localparam int         REP_W   = 4;
    localparam int         GAP_LEN = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pattern_tx_if #(.REP_W(REP_W)) bus ();

    pattern_tx #(
        .PAT_W   (PAT_W),
        .PATTERN (PAT),
        .REP_W   (REP_W),
        .GAP_LEN (GAP_LEN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // {dout, dvalid, busy, done}
    logic [3:0] obs;
    assign obs = {bus.dout, bus.dvalid, bus.busy, bus.done};

    logic [3:0] exp_q[$];

    // Cycle-by-cycle outputs after an accepted start: every pattern bit of every
    // repetition, optional idle gaps, one done cycle, then quiet.
    task automatic build_expect(input int r);
        logic [PAT_W-1:0] bits;
        bits = PAT;
        exp_q.delete();
        for (int k = 0; k < r; k++) begin
            for (int b = PAT_W - 1; b >= 0; b--)
                exp_q.push_back({bits[b], 1'b1, 1'b1, 1'b0});
`ifdef SEQ_TX_GAP_EN
            if (k < r - 1)
                for (int g = 0; g < GAP_LEN; g++) exp_q.push_back(4'b0010);
`endif
        end
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0000);
    endtask

    task automatic run_burst(input string name, input int r, input bit noise);
        build_expect(r);
        @(negedge clk);
        bus.start = 1'b1;
        bus.rep   = REP_W'(r);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            total++;
            if (obs !== exp_q[i]) begin
                bad++;
                $display("FAIL %s cycle %0d: dout/dvalid/busy/done got %b want %b", name, i + 1, obs, exp_q[i]);
            end
            bus.start = noise && exp_q[i][1] && ($urandom_range(0, 1) == 1);
            if (noise) bus.rep = REP_W'($urandom);
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.rep   = '0;
        bus.abort = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (obs !== 4'b0000) begin
            bad++;
            $display("FAIL reset_outputs: got %b want 0000", obs);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (obs !== 4'b0000) begin
            bad++;
            $display("FAIL post_reset_idle: got %b want 0000", obs);
        end
    endtask

    task automatic test_single();
        run_burst("single_rep1", 1, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_burst("rep3", 3, 1'b0);
    endtask

    task automatic test_ignored_starts();
        @(negedge clk);
        bus.start = 1'b1;
        bus.rep   = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (obs !== 4'b0000) begin
                bad++;
                $display("FAIL rep_zero cycle %0d: got %b want 0000", i + 1, obs);
            end
        end
        bus.rep   = REP_W'(3);
        bus.abort = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (obs !== 4'b0000) begin
                bad++;
                $display("FAIL abort_with_start cycle %0d: got %b want 0000", i + 1, obs);
            end
            bus.start = 1'b0;
            bus.abort = 1'b0;
        end
    endtask

    task automatic test_abort();
        build_expect(2);
        @(negedge clk);
        bus.start = 1'b1;
        bus.rep   = REP_W'(2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (obs !== exp_q[i]) begin
                bad++;
                $display("FAIL abort_pre cycle %0d: got %b want %b", i + 1, obs, exp_q[i]);
            end
            bus.start = 1'b0;
        end
        bus.abort = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (obs !== 4'b0000) begin
                bad++;
                $display("FAIL abort_post cycle %0d: got %b want 0000", i + 4, obs);
            end
            bus.abort = 1'b0;
        end
        run_burst("after_abort", 1, 1'b0);
    endtask

    task automatic test_reset_mid();
        build_expect(2);
        @(negedge clk);
        bus.start = 1'b1;
        bus.rep   = REP_W'(2);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (obs !== exp_q[i]) begin
                bad++;
                $display("FAIL rst_mid_pre cycle %0d: got %b want %b", i + 1, obs, exp_q[i]);
            end
            bus.start = 1'b0;
        end
        #1 rst = 1'b1;
        #1;
        total++;
        if (obs !== 4'b0000) begin
            bad++;
            $display("FAIL rst_async: got %b want 0000", obs);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (obs !== 4'b0000) begin
                bad++;
                $display("FAIL rst_mid_idle cycle %0d: got %b want 0000", i + 1, obs);
            end
        end
        run_burst("after_rst", 2, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            run_burst($sformatf("random_%0d", n), $urandom_range(1, 15), 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_ignored_starts();
        test_abort();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pattern_tx.md
PATTERN_TX -- requirements
Module: pattern_tx

Interface
REQ-001 Parameter PAT_W, default 6, pattern length in bits.
REQ-002 Parameter PATTERN, default 6'b100110, serial pattern, transmitted MSB first.
REQ-003 Parameter REP_W, default 4, width of repetition count.
REQ-004 Parameter GAP_LEN, default 2, idle cycles between repetitions (used only with SEQ_TX_GAP_EN).
REQ-005 clk  input  1  single clock; all state changes on posedge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 start  input  1  request to begin a burst; sampled only in IDLE.
REQ-008 rep  input  REP_W  number of pattern repetitions; latched on accepted start.
REQ-009 abort  input  1  synchronous burst cancel.
REQ-010 dout  output  1  serial data bit (the D line seen by a downstream detector).
REQ-011 dvalid  output  1  high while dout carries a pattern bit.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 done  output  1  one-cycle pulse on normal burst completion.

Function
REQ-014 States SHALL be IDLE, SEND, GAP; all outputs SHALL be registered.
REQ-015 IDLE: start=1 and rep!=0 at posedge -> SEND next cycle; rep latched into remaining-count; start with rep=0 ignored.
REQ-016 SEND: dout=PATTERN[idx], dvalid=1; idx starts at PAT_W-1, decrements by 1 each cycle.
REQ-017 First pattern bit SHALL appear on dout in the cycle immediately after the accepted start (latency 1).
REQ-018 At idx=0 with remaining>1: remaining decrements, idx reloads PAT_W-1, next state SEND (or GAP per REQ-027); no idle cycle otherwise.
REQ-019 At idx=0 with remaining=1: next state IDLE, done=1 for exactly that one IDLE cycle.
REQ-020 Outside SEND: dout=0, dvalid=0.
REQ-021 start while busy SHALL be ignored; rep changes while busy SHALL have no effect.
REQ-022 abort=1 in SEND or GAP -> IDLE next cycle, dout=0, dvalid=0, no done pulse.
REQ-023 abort and start together in IDLE: abort wins, start ignored.
REQ-024 Burst length SHALL be exactly rep*PAT_W dvalid cycles (plus gaps when enabled); remaining-count never wraps.

Reset
REQ-025 rst=1 SHALL force, asynchronously, state=IDLE, dout=0, dvalid=0, busy=0, done=0, idx=PAT_W-1, remaining=0.
REQ-026 rst asserted mid-burst SHALL discard the burst; after release, the block idles until a new start.

Configuration
REQ-027 With SEQ_TX_GAP_EN defined: between repetitions enter GAP for GAP_LEN cycles (dout=0, dvalid=0, busy=1), then SEND; GAP_LEN=0 skips GAP.
REQ-028 Without SEQ_TX_GAP_EN: GAP state and its counter SHALL not exist; repetitions are back-to-back.

Structure
REQ-029 Package pattern_tx_pkg SHALL hold the state enum and the default pattern constant 6'b100110.
REQ-030 Sub-module pattern_tx_shreg SHALL hold the PAT_W-bit load/shift register and bit index; FSM and rep/gap counters stay in pattern_tx.

Verification
REQ-031 rep=1, start pulse -> dout 1,0,0,1,1,0 with dvalid=1 on cycles 1-6 after start; done=1 on cycle 7; busy low from cycle 7.
REQ-032 rep=3, no gap macro -> 18 consecutive dvalid cycles, pattern 100110 three times, one done pulse on cycle 19.
REQ-033 SEQ_TX_GAP_EN, GAP_LEN=2, rep=2 -> 6 bits, 2 cycles dout=0/dvalid=0/busy=1, 6 bits, done on cycle 15.
REQ-034 abort on cycle 3 of rep=2 burst -> IDLE on cycle 4, dvalid=0, no done; new start then yields full pattern.
REQ-035 rst pulse mid-burst (cycle 4) -> all outputs 0 immediately, no done; start while busy and start with rep=0 both produce no activity.
